fp16_dot_acc: RTL

- Downstream neighbour of the combinational fp16 multiplier inside a systolic-array PE.
- Consumes a stream of IEEE-754 binary16 products and accumulates K_LEN consecutive products into one fp16 dot-product partial sum.
- Presents that sum on a valid/ready output port; the output stage is one registered slot.

---
 rtl/fp16_pkg.sv | 23 ++
 rtl/fp16_dot_acc_fp_add.sv | 102 ++++++++++
 rtl/fp16_dot_acc.sv | 77 +++++++
 3 files changed

// File: rtl/fp16_pkg.sv
// +----------------------------------------------------------------------+
// | fp16_pkg : binary16 field widths, special encodings, accumulator FSM |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package fp16_pkg;
   localparam int EXP_W = 5;
   localparam int MAN_W = 10;
   localparam int BIAS  = 15;

   localparam logic [15:0] FP16_QNAN = 16'h7E00;
   localparam logic [15:0] FP16_PINF = 16'h7C00;
   localparam logic [15:0] FP16_NINF = 16'hFC00;
   localparam logic [15:0] FP16_ZERO = 16'h0000;

   typedef enum logic [0:0] {
      ACC  = 1'b0,
      DONE = 1'b1
   } state_t;
endpackage

`default_nettype wire

// File: rtl/fp16_dot_acc_fp_add.sv
// +----------------------------------------------------------------------+
// | fp_add : combinational fp16 adder, RNE, subnormals flushed to zero    |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module fp_add
   import fp16_pkg::*;
(
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] sum
);

   logic             sa, sb;
   logic [EXP_W-1:0] ea, eb;
   logic [MAN_W-1:0] fa, fb;
   logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

   assign sa = a[15];
   assign sb = b[15];
   assign ea = a[14:10];
   assign eb = b[14:10];
   assign fa = a[9:0];
   assign fb = b[9:0];

   // Exponent zero covers both true zero and subnormals, which are flushed.
   assign a_zero = (ea == 5'd0);
   assign b_zero = (eb == 5'd0);
   assign a_inf  = (ea == 5'd31) && (fa == 10'd0);
   assign b_inf  = (eb == 5'd31) && (fb == 10'd0);
   assign a_nan  = (ea == 5'd31) && (fa != 10'd0);
   assign b_nan  = (eb == 5'd31) && (fb != 10'd0);

   logic              swap, big_s, found, round_up;
   logic [4:0]        big_e, sml_e, d;
   logic [10:0]       big_m, sml_m;
   logic [13:0]       big_x, sml_x, sml_sh, mask, norm;
   logic [14:0]       raw;
   logic [3:0]        lz;
   logic signed [6:0] exp_n, exp_f;
   logic [11:0]       mant_r;
   logic [9:0]        frac;

   always_comb begin
      swap   = {eb, fb} > {ea, fa};
      big_s  = swap ? sb : sa;
      big_e  = swap ? eb : ea;
      sml_e  = swap ? ea : eb;
      big_m  = swap ? {1'b1, fb} : {1'b1, fa};
      sml_m  = swap ? {1'b1, fa} : {1'b1, fb};
      d      = big_e - sml_e;
      big_x  = {big_m, 3'b000};
      sml_x  = {sml_m, 3'b000};
      mask   = 14'd0;
      sml_sh = 14'd1;
      if (d < 5'd14) begin
         mask   = (14'd1 << d) - 14'd1;
         sml_sh = (sml_x >> d) | {13'd0, |(sml_x & mask)};
      end

      if (sa == sb) raw = {1'b0, big_x} + {1'b0, sml_sh};
      else          raw = {1'b0, big_x} - {1'b0, sml_sh};

      lz    = 4'd0;
      found = 1'b0;
      for (int i = 13; i >= 0; i--) begin
         if (!found && raw[i]) begin
            lz    = 4'(13 - i);
            found = 1'b1;
         end
      end

      // Carry-out shifts right, keeping the dropped bit in sticky.
      if (raw[14]) begin
         norm  = {raw[14:2], raw[1] | raw[0]};
         exp_n = $signed({2'b00, big_e}) + 7'sd1;
      end else begin
         norm  = raw[13:0] << lz;
         exp_n = $signed({2'b00, big_e}) - $signed({3'b000, lz});
      end

      round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
      mant_r   = {1'b0, norm[13:3]} + {11'd0, round_up};
      exp_f    = exp_n + (mant_r[11] ? 7'sd1 : 7'sd0);
      frac     = mant_r[11] ? mant_r[10:1] : mant_r[9:0];

      if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) sum = FP16_QNAN;
      else if (a_inf)                  sum = sa ? FP16_NINF : FP16_PINF;
      else if (b_inf)                  sum = sb ? FP16_NINF : FP16_PINF;
      else if (a_zero && b_zero)       sum = {sa & sb, 15'd0};
      else if (a_zero)                 sum = b;
      else if (b_zero)                 sum = a;
      else if (raw == 15'd0)           sum = FP16_ZERO;
      else if (exp_f >= 7'sd31)        sum = big_s ? FP16_NINF : FP16_PINF;
      else if (exp_f < 7'sd1)          sum = FP16_ZERO;
      else                             sum = {big_s, exp_f[4:0], frac};
   end

endmodule

`default_nettype wire

// File: rtl/fp16_dot_acc.sv
// +----------------------------------------------------------------------+
// | fp16_dot_acc : sums K_LEN fp16 products, one-slot valid/ready output  |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module fp16_dot_acc
   import fp16_pkg::*;
#(
   parameter int K_LEN = 4,
   parameter int CNT_W = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_data,
   output logic        busy
);

   state_t             state, state_nxt;
   logic [15:0]        acc;
   logic [CNT_W-1:0]   cnt;
   logic [15:0]        add_sum, term_val;
   logic               accept, last;

   fp_add u_fp_add (
      .a   (acc),
      .b   (in_data),
      .sum (add_sum)
   );

   // The output slot frees up in the same cycle it is drained.
   assign in_ready  = (state == ACC) || out_ready;
   assign accept    = in_valid && in_ready;
   assign last      = (cnt == CNT_W'(K_LEN - 1));
   assign term_val  = (cnt == '0) ? in_data : add_sum;
   assign out_valid = (state == DONE);
   assign busy      = (cnt != '0);

   always_comb begin
      state_nxt = state;
      case (state)
         ACC:     if (accept && last) state_nxt = DONE;
         DONE:    if (accept && last) state_nxt = DONE;
                  else if (out_ready) state_nxt = ACC;
         default: state_nxt = ACC;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ACC;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc      <= FP16_ZERO;
         cnt      <= '0;
         out_data <= FP16_ZERO;
      end else if (accept) begin
         acc <= term_val;
         if (last) begin
            cnt      <= '0;
            out_data <= term_val;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

`default_nettype wire
